// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with hardware return-address stack
// Actions per edge, highest priority first: clr > ret > call > load > inc > hold.
module pc_call_stack #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [WIDTH-1:0]      i_in,
   input  logic                  i_load,
   input  logic                  i_inc,
   input  logic                  i_clr,
   input  logic                  i_call,
   input  logic                  i_ret,
   output logic [WIDTH-1:0]      o_out,
   output logic [DEPTH_LOG2:0]   o_depth,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam logic [DEPTH_LOG2:0]   LP_FULL  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LP_ONE_D = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] LP_ONE_I = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]      LP_ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]      r_stack [DEPTH];
   logic [WIDTH-1:0]      r_pc;
   logic [DEPTH_LOG2:0]   r_depth;
   logic                  r_overflow;
   logic                  r_underflow;

   logic [WIDTH-1:0]      w_pc_inc;
   logic [WIDTH-1:0]      w_pc_next;
   logic [DEPTH_LOG2:0]   w_depth_next;
   logic                  w_overflow_next;
   logic                  w_underflow_next;
   logic                  w_push;
   logic                  w_empty;
   logic                  w_full;
   logic [DEPTH_LOG2-1:0] w_push_idx;
   logic [DEPTH_LOG2-1:0] w_top_idx;

   assign w_pc_inc   = r_pc + LP_ONE_W;
   assign w_empty    = (r_depth == '0);
   assign w_full     = (r_depth == LP_FULL);
   assign w_push_idx = r_depth[DEPTH_LOG2-1:0];
   assign w_top_idx  = r_depth[DEPTH_LOG2-1:0] - LP_ONE_I;

   always_comb begin
      w_pc_next        = r_pc;
      w_depth_next     = r_depth;
      w_overflow_next  = 1'b0;
      w_underflow_next = 1'b0;
      w_push           = 1'b0;
      if (i_clr) begin
         w_pc_next = '0;
      end else if (i_ret) begin
         if (w_empty) begin
            w_underflow_next = 1'b1;
         end else begin
            w_pc_next    = r_stack[w_top_idx];
            w_depth_next = r_depth - LP_ONE_D;
         end
      end else if (i_call) begin
         // The jump is taken even when the push has to be dropped.
         w_pc_next = i_in;
         if (w_full) begin
            w_overflow_next = 1'b1;
         end else begin
            w_push       = 1'b1;
            w_depth_next = r_depth + LP_ONE_D;
         end
      end else if (i_load) begin
         w_pc_next = i_in;
      end else if (i_inc) begin
         w_pc_next = w_pc_inc;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pc        <= '0;
         r_depth     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_pc        <= w_pc_next;
         r_depth     <= w_depth_next;
         r_overflow  <= w_overflow_next;
         r_underflow <= w_underflow_next;
      end
   end

   // Stack storage is never cleared; depth alone decides which entries are live.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_reset) begin
         r_stack[w_push_idx] <= w_pc_inc;
      end
   end

   assign o_out       = r_pc;
   assign o_depth     = r_depth;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb/tb_pc_call_stack.sv - directed self-checking bench for pc_call_stack
module tb_pc_call_stack;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic        load, inc, clr, call, ret;
   logic [15:0] out;
   logic [3:0]  depth;
   logic        overflow, underflow;

   int errors = 0;
   int checks = 0;

   pc_call_stack #(.WIDTH(16), .DEPTH(8), .DEPTH_LOG2(3)) dut (
      .i_clk(clk), .i_reset(reset), .i_in(in), .i_load(load), .i_inc(inc),
      .i_clr(clr), .i_call(call), .i_ret(ret), .o_out(out), .o_depth(depth),
      .o_overflow(overflow), .o_underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic l, input logic i, input logic c, input logic ca,
                       input logic r, input logic [15:0] d);
      load = l; inc = i; clr = c; call = ca; ret = r; in = d;
      @(posedge clk);
      #1;
      load = 0; inc = 0; clr = 0; call = 0; ret = 0;
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (out !== 16'h0 || depth !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: out=%h depth=%0d ovf=%b unf=%b expected 0000/0/0/0", out, depth, overflow, underflow);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 16'h0);
      checks++;
      if (out !== 16'h0003) begin
         errors++;
         $display("FAIL inc_x3: out=%h expected 0003", out);
      end
   endtask

   task automatic test_wrap;
      step(1, 0, 0, 0, 0, 16'hFFFE);
      step(0, 1, 0, 0, 0, 16'h0);
      checks++;
      if (out !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_ffff: out=%h expected ffff", out);
      end
      step(0, 1, 0, 0, 0, 16'h0);
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_0000: out=%h expected 0000", out);
      end
   endtask

   task automatic test_call_ret;
      step(1, 0, 0, 0, 0, 16'h0010);
      step(0, 0, 0, 1, 0, 16'h0100);
      checks++;
      if (out !== 16'h0100 || depth !== 4'd1) begin
         errors++;
         $display("FAIL call_once: out=%h depth=%0d expected 0100/1", out, depth);
      end
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (out !== 16'h0011 || depth !== 4'd0) begin
         errors++;
         $display("FAIL ret_once: out=%h depth=%0d expected 0011/0", out, depth);
      end
   endtask

   task automatic test_overflow;
      logic [15:0] exp_ret;
      step(0, 0, 1, 0, 0, 16'h0);
      for (int k = 0; k < 9; k++) begin
         step(0, 0, 0, 1, 0, 16'h0200 + 16'(k));
         checks++;
         if (out !== (16'h0200 + 16'(k)) || depth !== ((k < 8) ? 4'(k + 1) : 4'd8)
             || overflow !== (k == 8)) begin
            errors++;
            $display("FAIL call_%0d: out=%h depth=%0d ovf=%b expected %h/%0d/%b",
                     k, out, depth, overflow, 16'h0200 + 16'(k),
                     (k < 8) ? k + 1 : 8, (k == 8));
         end
      end
      step(0, 0, 0, 0, 0, 16'h0);
      checks++;
      if (overflow !== 1'b0 || out !== 16'h0208 || depth !== 4'd8) begin
         errors++;
         $display("FAIL ovf_pulse_end: ovf=%b out=%h depth=%0d expected 0/0208/8", overflow, out, depth);
      end
      for (int j = 0; j < 8; j++) begin
         exp_ret = (j < 7) ? (16'h0207 - 16'(j)) : 16'h0001;
         step(0, 0, 0, 0, 1, 16'h0);
         checks++;
         if (out !== exp_ret || depth !== 4'(7 - j) || underflow !== 1'b0) begin
            errors++;
            $display("FAIL unwind_%0d: out=%h depth=%0d unf=%b expected %h/%0d/0",
                     j, out, depth, underflow, exp_ret, 7 - j);
         end
      end
   endtask

   task automatic test_underflow;
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (out !== 16'h0001 || depth !== 4'd0 || underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow: out=%h depth=%0d unf=%b expected 0001/0/1", out, depth, underflow);
      end
      step(0, 0, 0, 0, 0, 16'h0);
      checks++;
      if (underflow !== 1'b0 || out !== 16'h0001) begin
         errors++;
         $display("FAIL unf_pulse_end: unf=%b out=%h expected 0/0001", underflow, out);
      end
      step(0, 0, 0, 1, 0, 16'h0300);
      step(1, 0, 1, 0, 1, 16'h0555);
      checks++;
      if (out !== 16'h0000 || depth !== 4'd1 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_priority: out=%h depth=%0d unf=%b expected 0000/1/0", out, depth, underflow);
      end
   endtask

   task automatic test_back_to_back;
      step(0, 0, 0, 1, 1, 16'h0777);
      checks++;
      if (out !== 16'h0002 || depth !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ret_beats_call: out=%h depth=%0d ovf=%b expected 0002/0/0", out, depth, overflow);
      end
      step(1, 1, 0, 0, 0, 16'h1234);
      checks++;
      if (out !== 16'h1234) begin
         errors++;
         $display("FAIL load_beats_inc: out=%h expected 1234", out);
      end
      step(0, 0, 0, 1, 0, 16'hABCD);
      step(0, 0, 0, 1, 0, 16'h4000);
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (out !== 16'hABCE || depth !== 4'd1) begin
         errors++;
         $display("FAIL nested_ret1: out=%h depth=%0d expected abce/1", out, depth);
      end
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (out !== 16'h1235 || depth !== 4'd0) begin
         errors++;
         $display("FAIL nested_ret2: out=%h depth=%0d expected 1235/0", out, depth);
      end
   endtask

   task automatic test_reset_mid;
      step(0, 0, 1, 0, 0, 16'h0);
      step(0, 0, 0, 1, 0, 16'h0400);
      checks++;
      if (depth !== 4'd1 || out !== 16'h0400) begin
         errors++;
         $display("FAIL pre_reset_call: out=%h depth=%0d expected 0400/1", out, depth);
      end
      call = 1'b1;
      in   = 16'h0500;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out !== 16'h0000 || depth !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_call: out=%h depth=%0d expected 0000/0", out, depth);
      end
      @(posedge clk);
      #1;
      call = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (out !== 16'h0000 || depth !== 4'd0) begin
         errors++;
         $display("FAIL reset_held_edge: out=%h depth=%0d expected 0000/0", out, depth);
      end
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (underflow !== 1'b1 || out !== 16'h0000 || depth !== 4'd0) begin
         errors++;
         $display("FAIL post_reset_ret: unf=%b out=%h depth=%0d expected 1/0000/0", underflow, out, depth);
      end
   endtask

   initial begin
      reset = 1'b0;
      in = '0; load = 0; inc = 0; clr = 0; call = 0; ret = 0;
      test_reset;
      test_wrap;
      test_call_ret;
      test_overflow;
      test_underflow;
      test_back_to_back;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
